// File: rtl/hilo_acc_bank_if.sv
// Op/read bus of the HI/LO accumulator bank: op request channel, read port and
// in-flight accumulate status.
interface hilo_acc_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [SEL_W-1:0]  acc_sel;
    logic [DATA_W-1:0] hi_in;
    logic [DATA_W-1:0] lo_in;
    logic [SEL_W-1:0]  rd_sel;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              pending;
    logic [SEL_W-1:0]  pending_sel;

    modport master (
        output in_valid, op, acc_sel, hi_in, lo_in, rd_sel,
        input  in_ready, hi_out, lo_out, pending, pending_sel
    );

    modport slave (
        input  in_valid, op, acc_sel, hi_in, lo_in, rd_sel,
        output in_ready, hi_out, lo_out, pending, pending_sel
    );
endinterface

// File: rtl/hilo_acc_bank.sv
// Bank of HI/LO accumulator pairs: direct writes commit in one cycle, MADD/MSUB
// commit one cycle later through a single-entry pending stage.
module hilo_acc_bank #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned SEL_W   = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    hilo_acc_bank_if.slave  bus
);
    localparam logic [2:0] OpWhi   = 3'd1;
    localparam logic [2:0] OpWlo   = 3'd2;
    localparam logic [2:0] OpWboth = 3'd3;
    localparam logic [2:0] OpMadd  = 3'd4;
    localparam logic [2:0] OpMsub  = 3'd5;
    localparam logic [2:0] OpClr   = 3'd6;

    typedef enum logic {StIdle, StPend} state_e;

    state_e              r_state;
    logic [DATA_W-1:0]   r_hi [NUM_ACC];
    logic [DATA_W-1:0]   r_lo [NUM_ACC];
    logic [SEL_W-1:0]    r_psel;
    logic                r_psub;
    logic [2*DATA_W-1:0] r_addend;

    logic                w_is_nop;
    logic                w_is_acc;
    logic                w_ready;
    logic                w_accept;
    logic [2*DATA_W-1:0] w_cur;
    logic [2*DATA_W-1:0] w_res;

    always_comb begin
        w_is_nop = (bus.op == 3'd0) || (bus.op == 3'd7);
        w_is_acc = (bus.op == OpMadd) || (bus.op == OpMsub);
        // Only a same-target op collides with the in-flight accumulate.
        w_ready  = !((r_state == StPend) && (bus.acc_sel == r_psel) && !w_is_nop);
        w_accept = bus.in_valid && w_ready;
        w_cur    = {r_hi[r_psel], r_lo[r_psel]};
        w_res    = r_psub ? (w_cur - r_addend) : (w_cur + r_addend);
    end

    assign bus.in_ready    = w_ready;
    assign bus.hi_out      = r_hi[bus.rd_sel];
    assign bus.lo_out      = r_lo[bus.rd_sel];
    assign bus.pending     = (r_state == StPend);
    assign bus.pending_sel = r_psel;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= StIdle;
            r_hi     <= '{default: '0};
            r_lo     <= '{default: '0};
            r_psel   <= '0;
            r_psub   <= 1'b0;
            r_addend <= '0;
        end else begin
            if (r_state == StPend) begin
                r_hi[r_psel] <= w_res[2*DATA_W-1:DATA_W];
                r_lo[r_psel] <= w_res[DATA_W-1:0];
            end
            if (w_accept) begin
                case (bus.op)
                    OpWhi:   r_hi[bus.acc_sel] <= bus.hi_in;
                    OpWlo:   r_lo[bus.acc_sel] <= bus.lo_in;
                    OpWboth: begin
                        r_hi[bus.acc_sel] <= bus.hi_in;
                        r_lo[bus.acc_sel] <= bus.lo_in;
                    end
                    OpClr: begin
                        r_hi[bus.acc_sel] <= '0;
                        r_lo[bus.acc_sel] <= '0;
                    end
                    default: ;
                endcase
            end
            if (w_accept && w_is_acc) begin
                r_state  <= StPend;
                r_psel   <= bus.acc_sel;
                r_psub   <= (bus.op == OpMsub);
                r_addend <= {bus.hi_in, bus.lo_in};
            end else begin
                r_state  <= StIdle;
                r_psel   <= '0;
            end
        end
    end
endmodule
